// File: rtl/pwm_ctrl_defs.sv
// Shared definitions for the PWM LED dimmer controller:
// FSM state encoding and default sizing constants.
package pwm_ctrl_defs;

    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        BR_UP   = 2'd1,
        BR_DOWN = 2'd2
    } state_t;

    localparam int DEF_CNT_WIDTH = 8;
    localparam int DEF_PRESCALE  = 195;

endpackage

// File: rtl/pwm_led_dimmer_ctrl_if.sv
// Control/status bundle between the dimmer and its user:
// enable, mode, key pulses in; PWM, active duty, period pulse out.
interface pwm_led_dimmer_ctrl_if #(
    parameter int W = 8
);
    logic         en;
    logic         mode;
    logic         key_up;
    logic         key_down;
    logic         pwm_out;
    logic [W-1:0] duty;
    logic         period_start;

    modport master (
        output en, mode, key_up, key_down,
        input  pwm_out, duty, period_start
    );

    modport slave (
        input  en, mode, key_up, key_down,
        output pwm_out, duty, period_start
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles.
// Counter is cleared and held while en is low.
module tick_prescaler #(
    parameter int PRESCALE = 195
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = en && (pre_cnt == LAST);

    // Free-running modulo-PRESCALE counter, parked at zero when disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt <= '0;
        end else if (pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_led_dimmer_ctrl.sv
// PWM brightness generator for the LED bank: manual or breathing duty,
// with duty changes shadowed to period boundaries.
module pwm_led_dimmer_ctrl
    import pwm_ctrl_defs::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int PRESCALE       = DEF_PRESCALE,
    parameter int DUTY_STEP      = 16,
    parameter int BREATH_PERIODS = 4,
    parameter int INIT_DUTY      = 128
) (
    input logic                  clk,
    input logic                  rst,
    pwm_led_dimmer_ctrl_if.slave bus
);
    localparam int BW = (BREATH_PERIODS > 1) ? $clog2(BREATH_PERIODS) : 1;
    localparam logic [BW-1:0] BRK_LAST = BW'(BREATH_PERIODS - 1);
    localparam logic [CNT_WIDTH-1:0] ONES = '1;
    localparam logic [CNT_WIDTH-1:0] INIT = CNT_WIDTH'(INIT_DUTY);
    localparam logic [CNT_WIDTH:0] STEP = (CNT_WIDTH + 1)'(DUTY_STEP);
    localparam logic [CNT_WIDTH:0] MAXV = {1'b0, ONES};

    logic                 tick;
    logic                 wrap;
    logic [CNT_WIDTH-1:0] pwm_cnt;
    logic [CNT_WIDTH-1:0] duty_active;
    logic [CNT_WIDTH-1:0] duty_target;
    logic [BW-1:0]        brk_cnt;
    state_t               state;
    logic [CNT_WIDTH-1:0] up_val;
    logic [CNT_WIDTH-1:0] dn_val;
    logic [CNT_WIDTH:0]   sum;

    // Widened add so the carry shows an overshoot past all-ones
    assign sum    = {1'b0, duty_target} + STEP;
    assign up_val = (sum > MAXV) ? ONES : sum[CNT_WIDTH-1:0];
    assign dn_val = ({1'b0, duty_target} < STEP) ? '0
                  : duty_target - STEP[CNT_WIDTH-1:0];

    assign wrap = tick && (pwm_cnt == ONES);

    assign bus.duty = duty_active;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .tick(tick)
    );

    // PWM period counter, restarts from zero whenever enable drops
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Shadow duty at wrap, period pulse and registered compare output
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active      <= INIT;
            bus.period_start <= 1'b0;
            bus.pwm_out      <= 1'b0;
        end else begin
            bus.period_start <= wrap;
            bus.pwm_out      <= bus.en && (pwm_cnt < duty_active);
            if (wrap) begin
                duty_active <= duty_target;
            end
        end
    end

    // Duty source FSM: manual keys or breathing ramp stepped on wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MANUAL;
            duty_target <= INIT;
            brk_cnt     <= '0;
        end else begin
            unique case (state)
                MANUAL: begin
                    if (bus.mode) begin
                        state   <= BR_UP;
                        brk_cnt <= '0;
                    end else if (bus.key_up && !bus.key_down) begin
                        duty_target <= up_val;
                    end else if (bus.key_down && !bus.key_up) begin
                        duty_target <= dn_val;
                    end
                end
                BR_UP, BR_DOWN: begin
                    if (!bus.mode) begin
                        state <= MANUAL;
                    end else if (wrap) begin
                        if (brk_cnt == BRK_LAST) begin
                            brk_cnt <= '0;
                            if (state == BR_UP) begin
                                duty_target <= up_val;
                                if (up_val == ONES) state <= BR_DOWN;
                            end else begin
                                duty_target <= dn_val;
                                if (dn_val == '0) state <= BR_UP;
                            end
                        end else begin
                            brk_cnt <= brk_cnt + 1'b1;
                        end
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end
endmodule
